// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and the instruction consumer.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc8,
    input  imem_ready, imem_rdata, branch_taken, branch_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc8,
    output imem_ready, imem_rdata, branch_taken, branch_target, instr_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fetches words into a small {instr, pc} FIFO, redirects on taken branches.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus,
  output logic [31:0]   perf_fetches,
  output logic [31:0]   perf_flushes
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          reset_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic pop, accept, push;

  assign bus.instr_valid = (count_q != '0);
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign bus.imem_req    = !reset && !reset_q && ((count_q < DEPTH_C) || pop);
  assign accept          = bus.imem_req && bus.imem_ready;
  // A response accepted alongside a redirect belongs to the old path and is dropped.
  assign push            = accept && !bus.branch_taken;

  assign bus.imem_addr = pc_q;
  assign bus.instr     = bus.instr_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign bus.instr_pc  = bus.instr_valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign bus.instr_pc8 = bus.instr_pc + 32'd8;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.branch_taken) begin
      pc_d     = {bus.branch_target[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      reset_q  <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      reset_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetches_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetches_q <= 32'h0;
      perf_flushes_q <= 32'h0;
    end else begin
      if (accept)           perf_fetches_q <= perf_fetches_q + 32'd1;
      if (bus.branch_taken) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_fetches = 32'h0;
  assign perf_flushes = 32'h0;
`endif
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the controller and datapath. It owns the program counter and issues word requests to instruction memory. Returned instructions go into a 2-entry buffer, each tagged with its PC. The controller consumes instruction bits [31:12] and the datapath consumes the rest. A taken branch (`PCSrc` with the branch result) redirects fetch and flushes everything in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `DEPTH`, default 2: instruction buffer entries; legal values 2 or 4.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `imem_req  out  1`: fetch request to instruction memory.
- `imem_addr  out  32`: word-aligned fetch address; equals the current PC.
- `imem_ready  in  1`: memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata  in  32`: instruction word.
- `branch_taken  in  1`: redirect request (the controller's `PCSrc`).
- `branch_target  in  32`: redirect address; bits [1:0] are ignored and forced to 0.
- `instr_valid  out  1`: the buffer head holds a valid instruction.
- `instr_ready  in  1`: the consumer takes the buffer head this cycle.
- `instr  out  32`: buffer-head instruction; bits [31:12] drive the controller `Instruction` input.
- `instr_pc  out  32`: address of `instr`.
- `instr_pc8  out  32`: `instr_pc` + 8 (ARM R15 read value).
- `perf_fetches  out  32`: accepted-fetch count (see Configuration).
- `perf_flushes  out  32`: redirect count (see Configuration).

## Operation
- **PC register.** A request is accepted when `imem_req && imem_ready`. On acceptance, `pc <= pc + 4` with 32-bit wrap-around (32'hFFFF_FFFC goes to 0).
- **Request rule.** `imem_req = !reset_q && (count < DEPTH || pop)`, where `pop = instr_valid && instr_ready`.
  - `reset_q` is 1 for exactly the first cycle after reset deasserts.
  - While `imem_req` is high and `imem_ready` is low, `imem_addr` holds stable.
- **Buffer.** Circular FIFO of {instr, pc} entries with read and write pointers plus a count.
  - An accepted response pushes at the tail.
  - `pop` removes the head.
  - Push and pop in the same cycle leave `count` unchanged and are legal when full.
  - Push is never attempted when full without a pop; the request rule guarantees this.
- **Outputs.** `instr_valid = (count != 0)`. `instr` and `instr_pc` show the head entry and read 0 when empty.
- **Redirect.** When `branch_taken` = 1:
  - `pc <= {branch_target[31:2], 2'b00}`.
  - Buffer is flushed: count and both pointers go to 0.
  - A response accepted in the same cycle is discarded, and `pc` does not increment for it.
  - A same-cycle `pop` is ignored (the head is dropped, not delivered twice).
  - Redirect has priority over push, pop and increment.
- **Reset.** `reset` overrides everything, including a redirect:
  - `pc <= RESET_PC`, buffer empty, `reset_q <= 1`.
  - Outputs during and after reset: `imem_req` 0, `instr_valid` 0, `instr` 0, `instr_pc` 0, `instr_pc8` 8, counters 0.
  - Asserting reset mid-operation discards any outstanding acceptance in that cycle.

## Timing
- Fetch latency: response accepted at cycle N gives `instr_valid` = 1 at N+1.
- Redirect penalty: `branch_taken` at cycle N gives `imem_addr` = target at N+1, and the first target instruction is valid at N+2 at the earliest.
- Throughput: one instruction per cycle when `imem_ready` and `instr_ready` are held high.
- First request: cycle 2 after reset deasserts.
- Combinational paths:
  - `imem_req` depends combinationally on `instr_ready`, `instr_valid` and buffer state.
  - `imem_addr` and `instr` are register or buffer outputs only.
  - No path from `imem_ready` to any output.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetches` increments on every accepted request, including discarded ones.
  - `perf_flushes` increments on every `branch_taken` cycle outside reset.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both counter ports are tied to 0 and no counter registers are synthesised.

## Test plan
- **Reset and stream.** Reset with `RESET_PC` = 0, `imem_ready` = 1, `instr_ready` = 1 → `imem_addr` runs 0, 4, 8, 12; `instr_pc` lags by one cycle; `instr_pc8` = `instr_pc` + 8.
- **Back-pressure.** `instr_ready` = 0 for 5 cycles → after 2 accepts `imem_req` drops and `imem_addr` holds 8. Raising `instr_ready` delivers 0, then 4, then 8, with no duplicates or gaps.
- **Memory stall.** `imem_ready` = 0 for 3 cycles at address 12 → `imem_addr` stays 12 and `instr_valid` goes to 0 once the buffer drains.
- **Redirect collision.** `branch_taken` with `branch_target` = 32'h103, in the same cycle as an accepted response and a pop → next `imem_addr` = 32'h100. The discarded word never appears on `instr`, and `perf_flushes` = 1 (with the macro defined).
- **Wrap-around.** `RESET_PC` = 32'hFFFF_FFF8 → addresses FFF8, FFFC, 0000_0000, 0000_0004.
- **Reset mid-flight.** Buffer full (count = 2) and `branch_taken` = 1 in the same cycle as `reset` = 1 → next cycle `pc` = `RESET_PC`, `instr_valid` = 0, `imem_req` = 0.
